// File: rtl/ampa_apb_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ampa_apb_mem
// Purpose  : APB3 slave memory. It has a parametrised data width and depth,
//            a fixed number of wait states, byte write strobes, an optional
//            read-only upper region, and error responses for out-of-range
//            accesses and for writes into the read-only region.
// Ports    : P_clk    - clock, rising edge active
//            P_rst    - asynchronous active-low reset
//            P_addr   - word address (ADDR_WIDTH)
//            P_selx   - slave select
//            P_enable - access-phase indicator
//            P_write  - 1 = write, 0 = read
//            P_wdata  - write data (DATA_WIDTH)
//            P_strb   - byte write enables (DATA_WIDTH/8), ignored on reads
//            P_ready  - transfer complete
//            P_slverr - error response, only ever high together with P_ready
//            P_rdata  - read data register (DATA_WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
module ampa_apb_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = DEPTH
) (
  input  logic                    P_clk,
  input  logic                    P_rst,
  input  logic [ADDR_WIDTH-1:0]   P_addr,
  input  logic                    P_selx,
  input  logic                    P_enable,
  input  logic                    P_write,
  input  logic [DATA_WIDTH-1:0]   P_wdata,
  input  logic [DATA_WIDTH/8-1:0] P_strb,
  output logic                    P_ready,
  output logic                    P_slverr,
  output logic [DATA_WIDTH-1:0]   P_rdata
);

  localparam int                  c_NBYTES  = DATA_WIDTH / 8;
  localparam int                  c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]          c_WAIT    = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] c_DEPTH   = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_RO_BASE = ADDR_WIDTH'(RO_BASE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [c_IDX_W-1:0]      r_idx;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_NBYTES-1:0]     r_strb;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_done;
  logic                    w_latch;
  logic                    w_in_range;
  logic                    w_setup_err;
  logic [c_IDX_W-1:0]      w_rd_idx;

  // Completion is purely a decode of registered state, so P_ready has no
  // combinational path from the bus inputs.
  assign w_done     = (r_state == S_ACCESS) && (r_cnt == c_WAIT);
  assign w_latch    = (r_state == S_SETUP);

  // The error flag is computed from the same bus values that are being
  // latched on the SETUP->ACCESS edge, so it reflects the latched address.
  assign w_in_range  = (P_addr < c_DEPTH);
  assign w_setup_err = !w_in_range || (P_write && (P_addr >= c_RO_BASE));
  assign w_rd_idx    = P_addr[c_IDX_W-1:0];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // A select with enable already high is not a valid setup phase.
        if (P_selx && !P_enable) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_done) begin
          w_state_nxt = (P_selx && !P_enable) ? S_SETUP : S_IDLE;
        end else if (!P_selx) begin
          // Master abandoned the transfer before completion.
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter, error flag and read-data register
  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_cnt <= 4'd0;
        r_err <= w_setup_err;
        // Only reads touch the data register; it holds across writes.
        if (!P_write) begin
          r_rdata <= w_in_range ? r_mem[w_rd_idx] : '0;
        end
      end else if ((r_state == S_ACCESS) && !w_done) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Transfer payload and memory array. Neither is reset: the array keeps its
  // contents across reset, and a reset forces IDLE so a pending write can
  // never reach its completion edge.
  always_ff @(posedge P_clk) begin
    if (w_latch) begin
      r_idx   <= w_rd_idx;
      r_write <= P_write;
      r_wdata <= P_wdata;
      r_strb  <= P_strb;
    end
    if (w_done && r_write && !r_err) begin
      for (int i = 0; i < c_NBYTES; i++) begin
        if (r_strb[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign P_ready  = w_done;
  assign P_slverr = w_done && r_err;
  assign P_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ampa_apb_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ampa_apb_mem
// Purpose  : Self-checking bench for ampa_apb_mem. Two instances share one
//            bus: "main" (WAIT_STATES=2, RO_BASE=12) and "zero"
//            (WAIT_STATES=0, no read-only region); each has its own select.
//            A transaction-level model predicts, per clock cycle, when
//            P_ready must be high, the error response and the read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ampa_apb_mem;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DEP = 16;

  logic          P_clk    = 1'b0;
  logic          P_rst    = 1'b0;
  logic [AW-1:0] P_addr   = '0;
  logic          P_enable = 1'b0;
  logic          P_write  = 1'b0;
  logic [DW-1:0] P_wdata  = '0;
  logic [3:0]    P_strb   = '0;
  logic [1:0]    sel      = '0;

  logic          rdy_m, serr_m, rdy_z, serr_z;
  logic [DW-1:0] rdat_m, rdat_z;

  always #5 P_clk = ~P_clk;

  ampa_apb_mem #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEP),
    .WAIT_STATES(2),  .RO_BASE    (12)
  ) u_main (
    .P_clk   (P_clk),   .P_rst  (P_rst),  .P_addr  (P_addr),
    .P_selx  (sel[0]),  .P_enable(P_enable), .P_write(P_write),
    .P_wdata (P_wdata), .P_strb (P_strb), .P_ready (rdy_m),
    .P_slverr(serr_m),  .P_rdata(rdat_m)
  );

  ampa_apb_mem #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEP),
    .WAIT_STATES(0),  .RO_BASE    (DEP)
  ) u_zero (
    .P_clk   (P_clk),   .P_rst  (P_rst),  .P_addr  (P_addr),
    .P_selx  (sel[1]),  .P_enable(P_enable), .P_write(P_write),
    .P_wdata (P_wdata), .P_strb (P_strb), .P_ready (rdy_z),
    .P_slverr(serr_z),  .P_rdata(rdat_z)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_on = 1'b0;

  always @(posedge P_clk) cyc <= cyc + 1;

  // ---------------- reference model (per instance k) ----------------
  logic [31:0] mm [2][16];     // memory contents
  int          done_cyc [2];   // cycle in which P_ready must be high
  bit          exp_err  [2];   // error response of the pending transfer
  logic [31:0] rd_old   [2];   // read data before the latest read
  logic [31:0] rd_new   [2];   // read data of the latest read
  int          rd_cyc   [2];   // first cycle in which rd_new is visible

  function automatic int ws(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int ro(input int k);
    return (k == 0) ? 12 : 16;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      done_cyc[k] = -1;
      exp_err[k]  = 1'b0;
      rd_old[k]   = '0;
      rd_new[k]   = '0;
      rd_cyc[k]   = 0;
    end
  endtask

  task automatic cmp_inst(input int k, input logic r, input logic e, input logic [31:0] d);
    bit          er;
    logic [31:0] erd;
    string       nm;
    nm  = (k == 0) ? "main" : "zero";
    er  = (cyc == done_cyc[k]);
    erd = (cyc >= rd_cyc[k]) ? rd_new[k] : rd_old[k];
    chk($sformatf("%s ready", nm),  {31'd0, r}, {31'd0, er});
    chk($sformatf("%s slverr", nm), {31'd0, e}, {31'd0, er && exp_err[k]});
    chk($sformatf("%s rdata", nm),  d, erd);
  endtask

  // One compare process: every cycle, away from the active edge.
  always @(negedge P_clk) begin
    if (cmp_on) begin
      cmp_inst(0, rdy_m, serr_m, rdat_m);
      cmp_inst(1, rdy_z, serr_z, rdat_z);
    end
  end

  // ---------------- bus driver ----------------
  // Called right after a rising edge, with the target either idle or in its
  // completion cycle (back-to-back). Returns inside the completion cycle, or
  // one cycle after the abort took effect.
  task automatic xfer(input int k, input bit w, input int a, input logic [31:0] d,
                      input logic [3:0] s, input bit abort_it);
    bit err;
    sel      = '0;
    sel[k]   = 1'b1;
    P_enable = 1'b0;
    P_write  = w;
    P_addr   = a;
    P_wdata  = d;
    P_strb   = s;
    @(posedge P_clk); #1;
    P_enable = 1'b1;                       // slave is in its SETUP cycle now
    err         = (a >= DEP) || (w && (a >= ro(k)));
    exp_err[k]  = err;
    done_cyc[k] = cyc + ws(k) + 1;
    if (!w) begin
      rd_old[k] = rd_new[k];
      if (err) rd_new[k] = '0;
      else     rd_new[k] = mm[k][a];
      rd_cyc[k] = cyc + 1;
    end
    if (abort_it) begin
      @(posedge P_clk); #1;                // first ACCESS cycle
      sel[k]      = 1'b0;
      P_enable    = 1'b0;
      done_cyc[k] = -1;
      @(posedge P_clk); #1;
      return;
    end
    while (cyc < done_cyc[k]) begin
      @(posedge P_clk); #1;
      // Bus payload wiggles during ACCESS must not matter.
      P_addr  = $urandom_range(0, 31);
      P_wdata = $urandom;
      P_strb  = 4'($urandom);
      P_write = 1'($urandom);
    end
    if (w && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mm[k][a][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic idle(input int n);
    sel      = '0;
    P_enable = 1'b0;
    repeat (n) begin
      @(posedge P_clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    model_reset();
    repeat (3) @(posedge P_clk);
    #1;
    cmp_on = 1'b1;
    chk("reset main ready",  {31'd0, rdy_m},  32'd0);
    chk("reset main slverr", {31'd0, serr_m}, 32'd0);
    chk("reset main rdata",  rdat_m,          32'd0);
    chk("reset zero ready",  {31'd0, rdy_z},  32'd0);
    chk("reset zero slverr", {31'd0, serr_z}, 32'd0);
    chk("reset zero rdata",  rdat_z,          32'd0);

    // Backdoor preload of both arrays, mirrored into the model.
    for (int i = 0; i < DEP; i++) begin
      v = $urandom; mm[0][i] = v; u_main.r_mem[i] = v;
      v = $urandom; mm[1][i] = v; u_zero.r_mem[i] = v;
    end
    mm[0][12] = 32'hCAFE0001; u_main.r_mem[12] = 32'hCAFE0001;
    mm[0][7]  = 32'hA5A50007; u_main.r_mem[7]  = 32'hA5A50007;

    P_rst = 1'b1;
    idle(2);

    // Select with enable already high from IDLE is ignored.
    sel[0] = 1'b1; P_enable = 1'b1;
    repeat (3) begin @(posedge P_clk); #1; end
    idle(1);

    // Write then read
    xfer(0, 1'b1, 3, 32'hDEADBEEF, 4'hF, 1'b0);
    chk("wr3 ready", {31'd0, rdy_m}, 32'd1);
    chk("wr3 slverr", {31'd0, serr_m}, 32'd0);
    idle(2);
    xfer(0, 1'b0, 3, 32'h0, 4'h0, 1'b0);
    chk("rd3 data", rdat_m, 32'hDEADBEEF);
    idle(1);

    // Byte strobes, back to back, then a zero-strobe no-op
    xfer(0, 1'b1, 5, 32'h11223344, 4'hF, 1'b0);
    xfer(0, 1'b1, 5, 32'hAABBCCDD, 4'b0101, 1'b0);
    xfer(0, 1'b0, 5, 32'h0, 4'h0, 1'b0);
    chk("rd5 strobes", rdat_m, 32'h11BB33DD);
    xfer(0, 1'b1, 5, 32'hFFFFFFFF, 4'h0, 1'b0);
    chk("wr5 zero strobe slverr", {31'd0, serr_m}, 32'd0);
    xfer(0, 1'b0, 5, 32'h0, 4'h0, 1'b0);
    chk("rd5 after no-op", rdat_m, 32'h11BB33DD);
    idle(1);

    // Out of range
    xfer(0, 1'b1, 20, 32'h12345678, 4'hF, 1'b0);
    chk("wr20 slverr", {31'd0, serr_m}, 32'd1);
    idle(1);
    xfer(0, 1'b0, 20, 32'h0, 4'h0, 1'b0);
    chk("rd20 slverr", {31'd0, serr_m}, 32'd1);
    chk("rd20 data", rdat_m, 32'd0);
    idle(1);

    // Read-only region
    xfer(0, 1'b1, 12, 32'h0, 4'hF, 1'b0);
    chk("wr12 slverr", {31'd0, serr_m}, 32'd1);
    xfer(0, 1'b0, 12, 32'h0, 4'h0, 1'b0);
    chk("rd12 data", rdat_m, 32'hCAFE0001);
    chk("rd12 slverr", {31'd0, serr_m}, 32'd0);
    idle(1);

    // Abort: no write, no ready, FSM idle (next transfer has normal latency)
    xfer(0, 1'b1, 7, 32'h00000055, 4'hF, 1'b1);
    idle(3);
    xfer(0, 1'b0, 7, 32'h0, 4'h0, 1'b0);
    chk("rd7 after abort", rdat_m, 32'hA5A50007);
    idle(1);

    // Reset asserted in the middle of a read's ACCESS phase
    sel = 2'b01; P_enable = 1'b0; P_write = 1'b0; P_addr = 3;
    @(posedge P_clk); #1;
    P_enable    = 1'b1;
    exp_err[0]  = 1'b0;
    done_cyc[0] = cyc + 3;
    rd_old[0]   = rd_new[0];
    rd_new[0]   = mm[0][3];
    rd_cyc[0]   = cyc + 1;
    @(posedge P_clk); #1;
    chk("mid-read data loaded", rdat_m, 32'hDEADBEEF);
    #1;
    P_rst = 1'b0;
    model_reset();
    #1;
    chk("async reset ready",  {31'd0, rdy_m},  32'd0);
    chk("async reset slverr", {31'd0, serr_m}, 32'd0);
    chk("async reset rdata",  rdat_m,          32'd0);
    sel = '0; P_enable = 1'b0;
    @(posedge P_clk); #1;
    P_rst = 1'b1;
    idle(2);

    // Zero-wait instance: back-to-back writes then back-to-back reads
    for (int i = 0; i < 4; i++) xfer(1, 1'b1, i, 32'h0BAD0000 + 32'(i), 4'hF, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b0, i, 32'h0, 4'h0, 1'b0);
      chk($sformatf("zero rd%0d", i), rdat_z, 32'h0BAD0000 + 32'(i));
    end
    idle(1);

    // Randomized traffic on both instances
    repeat (400) begin
      int  k, a;
      bit  w, ab;
      k  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      w  = 1'($urandom);
      a  = $urandom_range(0, 19);
      ab = (k == 0) && ($urandom_range(0, 15) == 0);
      xfer(k, w, a, $urandom, 4'($urandom), ab);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ampa_apb_mem.md
# ampa_apb_mem

Parametrised APB3 slave memory and the next generation of the `ampa_apb` slave. It adds configurable data width and depth, programmable wait-state insertion, byte write strobes, a read-only upper region, and error responses for out-of-range or illegal accesses. It sits behind the APB bridge as a register/scratch memory target and drives `P_ready`, `P_slverr` and `P_rdata` back to the master.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width; multiple of 8, 8..64.
- `ADDR_WIDTH`, 32: width of `P_addr`.
- `DEPTH`, 16: number of words; word-indexed, so address N selects word N.
- `WAIT_STATES`, 0: access-phase cycles with `P_ready` low before completion; 0..15.
- `RO_BASE`, `DEPTH`: first read-only word address. `RO_BASE = DEPTH` means no read-only region.

Ports:
- `P_clk`, in, 1: clock; rising edge active.
- `P_rst`, in, 1: reset; asynchronous assert, active-low, synchronous deassert externally.
- `P_addr`, in, `ADDR_WIDTH`: word address.
- `P_selx`, in, 1: slave select.
- `P_enable`, in, 1: access-phase indicator.
- `P_write`, in, 1: 1 = write, 0 = read.
- `P_wdata`, in, `DATA_WIDTH`: write data.
- `P_strb`, in, `DATA_WIDTH/8`: byte write enables; ignored on reads.
- `P_ready`, out, 1: transfer complete.
- `P_slverr`, out, 1: error response; valid only while `P_ready`=1.
- `P_rdata`, out, `DATA_WIDTH`: read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when `P_selx`=1 and `P_enable`=0.
  - `P_selx`=1 with `P_enable`=1 while in IDLE is ignored; the FSM stays in IDLE.
  - SETUP -> ACCESS unconditionally. On this edge, latch `P_addr`, `P_write`, `P_wdata` and `P_strb`, and clear the wait counter.
  - ACCESS, counter < `WAIT_STATES`: increment the counter and stay in ACCESS.
  - ACCESS, counter == `WAIT_STATES` (completion cycle): go to SETUP if `P_selx`=1 and `P_enable`=0 on the completion edge; otherwise go to IDLE.
  - ACCESS with `P_selx`=0 before completion is an abort: go to IDLE, no memory write, no `P_ready` pulse.
- `P_ready` is a combinational decode of (state == ACCESS && counter == `WAIT_STATES`) only. It has no combinational path from inputs.
- Error conditions, evaluated on the latched address:
  - latched address >= `DEPTH` gives `P_slverr`=1 for reads and writes.
  - a write with address in `RO_BASE`..`DEPTH`-1 gives `P_slverr`=1.
- Writes commit on the completion edge, only for byte lanes with `P_strb[i]`=1 and only when there is no error. A strobe of all zeros is a legal no-op with `P_slverr`=0.
- Reads: the memory is read on the SETUP->ACCESS edge into the `P_rdata` register.
  - An errored read loads `P_rdata`=0.
  - `P_rdata` holds its value until the next read enters ACCESS. Writes do not change it.
- Memory array is not reset; contents survive `P_rst`. Only the FSM, counter and outputs are reset.

## Timing
- Reset values: `P_ready`=0, `P_slverr`=0, `P_rdata`=0, state IDLE, counter 0. Assertion of `P_rst` takes effect immediately, mid-transfer included. The pending write is dropped.
- Latency from SETUP cycle to the `P_ready` cycle is `WAIT_STATES`+1 cycles. With `WAIT_STATES`=0, `P_ready`=1 in the first ACCESS cycle.
- Back-to-back transfers take `WAIT_STATES`+2 cycles each, with no idle cycle between them.
- `P_slverr` is 0 in every cycle where `P_ready`=0.
- A read that follows a write to the same address in the next transfer returns the new data; the write commits before the next SETUP->ACCESS edge.
- `P_addr`, `P_write`, `P_wdata` and `P_strb` changing during ACCESS have no effect, because values are latched at SETUP.

## Test plan
Bench configuration unless noted: `DATA_WIDTH`=32, `DEPTH`=16, `WAIT_STATES`=2, `RO_BASE`=12.
- **Write then read:** write 0xDEADBEEF to address 3 with strobe 4'hF, then read address 3.
  - Required: `P_ready` high only in the 3rd ACCESS cycle of each transfer, `P_rdata`=0xDEADBEEF, `P_slverr`=0.
- **Byte strobes:** write 0x11223344 to address 5 with strobe 4'hF, write 0xAABBCCDD to address 5 with strobe 4'b0101, then read address 5.
  - Required: read returns 0x11BB33DD.
- **Out of range:** write 0x12345678 to address 20, then read address 20.
  - Required: `P_slverr`=1 in both completion cycles, read `P_rdata`=0.
  - Required: `P_slverr`=0 in all other cycles.
- **Read-only region:** preload 0xCAFE0001 to address 12 via the array backdoor, then write 0 to address 12.
  - Required: `P_slverr`=1; a following read of address 12 returns 0xCAFE0001 with `P_slverr`=0.
- **Abort and reset:**
  - Write 0x55 to address 7, dropping `P_selx` in ACCESS cycle 1. Required: word 7 unchanged, no `P_ready` pulse, FSM back in IDLE.
  - Assert `P_rst` low mid-ACCESS of a read. Required: `P_ready`=0, `P_slverr`=0 and `P_rdata`=0 immediately, before the next clock edge.
- **Zero-wait back-to-back** (instance with `WAIT_STATES`=0): 4 consecutive writes to addresses 0..3 with no idle cycle between them.
  - Required: `P_ready` high in every 2nd cycle.
  - Required: readback of addresses 0..3 returns the written values.
